// File: rtl/multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_sequencer
// Purpose  : Control sequencer for a multicycle RV32I-style datapath. It walks
//            FETCH -> DECODE -> EXEC -> [MEM] -> [WB], issues the memory,
//            register-file and PC strobes, and traps on illegal opcodes,
//            illegal branch funct3 codes, or a memory acknowledge timeout.
// Ports    : clk, rst_n           - clock, asynchronous active-low reset
//            op, funct3           - instruction fields (stable DECODE..WB)
//            imem_ack, dmem_ack   - memory acknowledges
//            br_taken             - ALU branch-compare result
//            imem_req, ir_we      - fetch request / IR load strobe
//            dmem_req, dmem_we    - data request / store qualifier
//            rf_we, pc_we, pc_sel - register-file and PC update controls
//            trap, state          - trap flag / current state code
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       br_taken,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       rf_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       trap,
    output logic [2:0] state
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_TRAP   = 3'd7;

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_ALUI   = 7'b0010011;
    localparam logic [6:0] c_OP_ALU    = 7'b0110011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [1:0] c_PC_PLUS4 = 2'b00;
    localparam logic [1:0] c_PC_REL   = 2'b01;
    localparam logic [1:0] c_PC_REG   = 2'b10;

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [7:0] r_wait_cnt;
    logic [7:0] w_wait_cnt_next;

    logic w_is_load, w_is_store, w_is_alu, w_is_jump, w_is_branch;
    logic w_legal, w_br_illegal;

    logic       w_imem_req, w_ir_we, w_dmem_req, w_dmem_we;
    logic       w_rf_we, w_pc_we, w_trap;
    logic [1:0] w_pc_sel;

    assign w_is_load    = (op == c_OP_LOAD);
    assign w_is_store   = (op == c_OP_STORE);
    assign w_is_alu     = (op == c_OP_ALUI) || (op == c_OP_ALU);
    assign w_is_jump    = (op == c_OP_JAL) || (op == c_OP_JALR);
    assign w_is_branch  = (op == c_OP_BRANCH);
    assign w_legal      = w_is_load || w_is_store || w_is_alu || w_is_jump || w_is_branch;
    assign w_br_illegal = (funct3 == 3'b010) || (funct3 == 3'b011);

    // Next-state and strobe decode. Strobes depend on the current state and,
    // where the protocol requires a same-cycle response, on ack/br_taken.
    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_ir_we      = 1'b0;
        w_dmem_req   = 1'b0;
        w_dmem_we    = 1'b0;
        w_rf_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_sel     = c_PC_PLUS4;
        w_trap       = 1'b0;

        case (r_state)
            c_FETCH: begin
                w_imem_req = 1'b1;
                w_ir_we    = imem_ack;
                // An ack in the timeout cycle still completes the fetch.
                if (imem_ack)
                    w_next_state = c_DECODE;
                else if (r_wait_cnt == c_TIMEOUT)
                    w_next_state = c_TRAP;
            end

            c_DECODE: begin
                w_next_state = w_legal ? c_EXEC : c_TRAP;
            end

            c_EXEC: begin
                if (w_is_load || w_is_store) begin
                    w_next_state = c_MEM;
                end else if (w_is_alu || w_is_jump) begin
                    w_next_state = c_WB;
                end else if (w_is_branch && !w_br_illegal) begin
                    w_pc_we      = 1'b1;
                    w_pc_sel     = br_taken ? c_PC_REL : c_PC_PLUS4;
                    w_next_state = c_FETCH;
                end else begin
                    w_next_state = c_TRAP;
                end
            end

            c_MEM: begin
                w_dmem_req = 1'b1;
                w_dmem_we  = w_is_store;
                if (dmem_ack) begin
                    if (w_is_store) begin
                        w_pc_we      = 1'b1;
                        w_next_state = c_FETCH;
                    end else begin
                        w_next_state = c_WB;
                    end
                end else if (r_wait_cnt == c_TIMEOUT) begin
                    w_next_state = c_TRAP;
                end
            end

            c_WB: begin
                w_rf_we      = 1'b1;
                w_pc_we      = 1'b1;
                w_next_state = c_FETCH;
                if (op == c_OP_JAL)
                    w_pc_sel = c_PC_REL;
                else if (op == c_OP_JALR)
                    w_pc_sel = c_PC_REG;
            end

            c_TRAP: begin
                w_trap = 1'b1;
            end

            // Unused codes 5 and 6 fall into TRAP on the next edge.
            default: begin
                w_next_state = c_TRAP;
            end
        endcase
    end

    // Wait counter restarts on every state change and only counts cycles spent
    // waiting for an acknowledge in FETCH or MEM.
    always_comb begin
        w_wait_cnt_next = r_wait_cnt;
        if (w_next_state != r_state)
            w_wait_cnt_next = 8'd0;
        else if (((r_state == c_FETCH) && !imem_ack) || ((r_state == c_MEM) && !dmem_ack))
            w_wait_cnt_next = r_wait_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Reset holds state at FETCH, but FETCH alone would raise imem_req; the
    // outputs are therefore qualified by rst_n so every strobe is low while
    // reset is applied and drops the instant it is asserted.
    assign imem_req = rst_n & w_imem_req;
    assign ir_we    = rst_n & w_ir_we;
    assign dmem_req = rst_n & w_dmem_req;
    assign dmem_we  = rst_n & w_dmem_we;
    assign rf_we    = rst_n & w_rf_we;
    assign pc_we    = rst_n & w_pc_we;
    assign pc_sel   = rst_n ? w_pc_sel : c_PC_PLUS4;
    assign trap     = rst_n & w_trap;
    assign state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_sequencer
// Purpose  : Self-checking bench for multicycle_sequencer. A behavioural model
//            expands each instruction (opcode, funct3, branch outcome, ack
//            delays) into the expected per-cycle trace of state and strobes,
//            which is then compared cycle by cycle against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_sequencer;

    localparam int unsigned TIMEOUT = 3;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       imem_ack = 1'b0;
    logic       dmem_ack = 1'b0;
    logic       br_taken = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, trap;
    logic [1:0] pc_sel;
    logic [2:0] state;

    always #5 clk = ~clk;

    multicycle_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .op       (op),
        .funct3   (funct3),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .br_taken (br_taken),
        .imem_req (imem_req),
        .ir_we    (ir_we),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .rf_we    (rf_we),
        .pc_we    (pc_we),
        .pc_sel   (pc_sel),
        .trap     (trap),
        .state    (state)
    );

    // Observed vector: {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap}
    logic [11:0] obs;
    assign obs = {state, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_sel, trap};

    typedef struct packed {
        logic [11:0] exp;
        logic        iack;
        logic        dack;
    } cyc_t;

    cyc_t plan[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef enum int {K_LOAD, K_STORE, K_ALU, K_JAL, K_JALR, K_BRANCH, K_ILLEGAL} kind_t;

    function automatic kind_t classify(input logic [6:0] o);
        case (o)
            OP_LOAD:          return K_LOAD;
            OP_STORE:         return K_STORE;
            OP_ALUI, OP_ALU:  return K_ALU;
            OP_JAL:           return K_JAL;
            OP_JALR:          return K_JALR;
            OP_BRANCH:        return K_BRANCH;
            default:          return K_ILLEGAL;
        endcase
    endfunction

    function automatic logic [11:0] mk(input logic [2:0] st, input logic ireq, input logic irwe,
                                       input logic dreq, input logic dwe, input logic rfwe,
                                       input logic pcwe, input logic [1:0] sel, input logic trp);
        return {st, ireq, irwe, dreq, dwe, rfwe, pcwe, sel, trp};
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    function automatic void add(input logic [11:0] e, input logic ia, input logic da);
        cyc_t c;
        c.exp  = e;
        c.iack = ia;
        c.dack = da;
        plan.push_back(c);
    endfunction

    // Expected trace of one instruction. fd/md are the number of cycles the
    // memory withholds its ack; more than TIMEOUT waits means a timeout trap.
    // Acks in states that do not wait for them are randomised to show they are ignored.
    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3, input logic tk,
                              input int fd, input int md, output bit trapped);
        kind_t k;
        logic  st;
        logic [1:0] sel;
        plan.delete();
        trapped = 1'b0;
        if (fd > int'(TIMEOUT)) begin
            for (int i = 0; i <= int'(TIMEOUT); i++) add(mk(S_FETCH,1,0,0,0,0,0,2'b00,0), 1'b0, rnd());
            trapped = 1'b1;
            return;
        end
        for (int i = 0; i < fd; i++) add(mk(S_FETCH,1,0,0,0,0,0,2'b00,0), 1'b0, rnd());
        add(mk(S_FETCH,1,1,0,0,0,0,2'b00,0), 1'b1, rnd());
        add(mk(S_DECODE,0,0,0,0,0,0,2'b00,0), rnd(), rnd());
        k = classify(o);
        if (k == K_ILLEGAL) begin
            trapped = 1'b1;
            return;
        end
        if (k == K_BRANCH) begin
            if (f3 == 3'b010 || f3 == 3'b011) begin
                add(mk(S_EXEC,0,0,0,0,0,0,2'b00,0), rnd(), rnd());
                trapped = 1'b1;
            end else begin
                add(mk(S_EXEC,0,0,0,0,0,1,tk ? 2'b01 : 2'b00,0), rnd(), rnd());
            end
            return;
        end
        add(mk(S_EXEC,0,0,0,0,0,0,2'b00,0), rnd(), rnd());
        if (k == K_LOAD || k == K_STORE) begin
            st = (k == K_STORE);
            if (md > int'(TIMEOUT)) begin
                for (int i = 0; i <= int'(TIMEOUT); i++) add(mk(S_MEM,0,0,1,st,0,0,2'b00,0), rnd(), 1'b0);
                trapped = 1'b1;
                return;
            end
            for (int i = 0; i < md; i++) add(mk(S_MEM,0,0,1,st,0,0,2'b00,0), rnd(), 1'b0);
            add(mk(S_MEM,0,0,1,st,0,st,2'b00,0), rnd(), 1'b1);
            if (st) return;
        end
        sel = (k == K_JAL) ? 2'b01 : (k == K_JALR) ? 2'b10 : 2'b00;
        add(mk(S_WB,0,0,0,0,1,1,sel,0), rnd(), rnd());
    endtask

    // Runs one instruction from a point just after a rising edge; if it traps,
    // holds TRAP for trap_cycles and then resets the DUT.
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic tk, input int fd, input int md, input int trap_cycles);
        bit trapped;
        build_plan(o, f3, tk, fd, md, trapped);
        if (trapped)
            for (int i = 0; i < trap_cycles; i++) add(mk(S_TRAP,0,0,0,0,0,0,2'b00,1), rnd(), rnd());
        op       = o;
        funct3   = f3;
        br_taken = tk;
        foreach (plan[i]) begin
            imem_ack = plan[i].iack;
            dmem_ack = plan[i].dack;
            @(negedge clk);
            n_checks++;
            if (obs !== plan[i].exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h {state,ireq,irwe,dreq,dwe,rfwe,pcwe,pcsel,trap}",
                         name, i, obs, plan[i].exp);
            end
            @(posedge clk);
            #1;
        end
        if (trapped) begin
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            rst_n    = 1'b0;
            #1;
            n_checks++;
            if (obs !== 12'h000) begin
                n_fail++;
                $display("FAIL %s reset_from_trap: got %h expected %h", name, obs, 12'h000);
            end
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            rst_n    = 1'b1;
            #1;
            n_checks++;
            if (obs !== mk(S_FETCH,1,0,0,0,0,0,2'b00,0)) begin
                n_fail++;
                $display("FAIL %s release_fetch: got %h expected %h", name, obs, mk(S_FETCH,1,0,0,0,0,0,2'b00,0));
            end
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        op       = OP_STORE;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected %h", obs, 12'h000);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        rst_n    = 1'b1;
        #1;
        n_checks++;
        if (obs !== mk(S_FETCH,1,0,0,0,0,0,2'b00,0)) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, mk(S_FETCH,1,0,0,0,0,0,2'b00,0));
        end
    endtask

    task automatic test_alu();
        run_instr("alu_reg", OP_ALU, 3'b000, 1'b0, 0, 0, 0);
        run_instr("alu_imm", OP_ALUI, 3'b111, 1'b1, 1, 0, 0);
        run_instr("jal", OP_JAL, 3'b000, 1'b0, 0, 0, 0);
        run_instr("jalr", OP_JALR, 3'b000, 1'b0, 2, 0, 0);
    endtask

    task automatic test_load_store();
        run_instr("load_3wait", OP_LOAD, 3'b010, 1'b0, 0, 3, 0);
        run_instr("store_0wait", OP_STORE, 3'b010, 1'b0, 0, 0, 0);
        run_instr("store_2wait", OP_STORE, 3'b000, 1'b1, 1, 2, 0);
    endtask

    task automatic test_branch();
        run_instr("branch_taken", OP_BRANCH, 3'b000, 1'b1, 0, 0, 0);
        run_instr("branch_not_taken", OP_BRANCH, 3'b101, 1'b0, 0, 0, 0);
        run_instr("branch_f3_010", OP_BRANCH, 3'b010, 1'b1, 0, 0, 3);
        run_instr("branch_f3_011", OP_BRANCH, 3'b011, 1'b0, 0, 0, 2);
    endtask

    task automatic test_illegal();
        run_instr("illegal_op", 7'b1111111, 3'b000, 1'b0, 0, 0, 20);
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout", OP_ALU, 3'b000, 1'b0, 4, 0, 3);
        run_instr("fetch_ack_wins", OP_ALU, 3'b000, 1'b0, 3, 0, 0);
        run_instr("mem_timeout", OP_LOAD, 3'b000, 1'b0, 0, 4, 2);
        run_instr("mem_ack_wins", OP_LOAD, 3'b000, 1'b0, 3, 3, 0);
    endtask

    task automatic test_async_reset_mem();
        op       = OP_STORE;
        funct3   = 3'b010;
        imem_ack = 1'b1;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if (obs !== mk(S_MEM,0,0,1,1,0,0,2'b00,0)) begin
            n_fail++;
            $display("FAIL async_rst_in_mem: got %h expected %h", obs, mk(S_MEM,0,0,1,1,0,0,2'b00,0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dmem_req, dmem_we, state} !== 5'b00000) begin
            n_fail++;
            $display("FAIL async_rst_drop: got dreq=%b dwe=%b state=%0d expected 0 0 0", dmem_req, dmem_we, state);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (obs !== mk(S_FETCH,1,0,0,0,0,0,2'b00,0)) begin
            n_fail++;
            $display("FAIL async_rst_release: got %h expected %h", obs, mk(S_FETCH,1,0,0,0,0,0,2'b00,0));
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        logic [6:0] o;
        int fd, md;
        ops[0] = OP_LOAD;  ops[1] = OP_STORE; ops[2] = OP_ALUI; ops[3] = OP_ALU;
        ops[4] = OP_JAL;   ops[5] = OP_JALR;  ops[6] = OP_BRANCH;
        for (int n = 0; n < 150; n++) begin
            o  = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            fd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
            md = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 2));
            run_instr("random", o, 3'($urandom), 1'($urandom), fd, md, int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_illegal();
        test_timeout();
        test_async_reset_mem();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum wait cycles for a memory ack before trapping (range 1..255).
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: op  input  7  opcode field from the instruction register; stable from DECODE through WB.
REQ-005 Port: funct3  input  3  funct3 field from the instruction register.
REQ-006 Port: imem_ack  input  1  instruction-memory data valid.
REQ-007 Port: dmem_ack  input  1  data-memory transfer complete.
REQ-008 Port: br_taken  input  1  ALU branch-compare result.
REQ-009 Port: imem_req  output  1  instruction fetch request.
REQ-010 Port: ir_we  output  1  instruction register load strobe.
REQ-011 Port: dmem_req  output  1  data-memory request.
REQ-012 Port: dmem_we  output  1  data-memory write qualifier (store).
REQ-013 Port: rf_we  output  1  register-file write strobe.
REQ-014 Port: pc_we  output  1  PC update strobe.
REQ-015 Port: pc_sel  output  2  next-PC select: 00 = PC+4, 01 = PC+imm, 10 = rs1+imm.
REQ-016 Port: trap  output  1  illegal-opcode or timeout trap flag.
REQ-017 Port: state  output  3  current state encoding.

Function
REQ-018 State encodings SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; codes 5 and 6 SHALL go to TRAP on the next clock.
REQ-019 Outside the states and conditions listed below, all strobes SHALL be 0 and pc_sel SHALL be 00.
REQ-020 FETCH: imem_req=1; ir_we SHALL equal imem_ack in the same cycle (Mealy); on ack, next state SHALL be DECODE.
REQ-021 DECODE (1 cycle): next state SHALL be EXEC for legal op values 0000011, 0100011, 0010011, 0110011, 1101111, 1100111, 1100011, and TRAP for any other op.
REQ-022 EXEC, load or store: next state SHALL be MEM.
REQ-023 EXEC, ALU or jump: next state SHALL be WB.
REQ-024 EXEC, branch, funct3 in {000,001,100,101,110,111}: pc_we=1, pc_sel=01 if br_taken else 00, next state FETCH.
REQ-025 EXEC, branch, funct3 010 or 011: next state SHALL be TRAP with no pc_we.
REQ-026 MEM: dmem_req=1 and dmem_we=1 only for store (0100011); on dmem_ack, a store SHALL assert pc_we with pc_sel=00 and go to FETCH, and a load SHALL go to WB.
REQ-027 WB: rf_we=1 and pc_we=1 for one cycle; pc_sel SHALL be 01 for 1101111, 10 for 1100111, and 00 otherwise; next state FETCH.
REQ-028 Wait counter: 8-bit; cleared on every state change; increments each FETCH/MEM cycle without ack.
REQ-029 Timeout: when the counter equals TIMEOUT and ack is 0, next state SHALL be TRAP; an ack in that same cycle SHALL win over the timeout.
REQ-030 Acks arriving outside FETCH (imem_ack) or MEM (dmem_ack) SHALL be ignored.
REQ-031 TRAP: trap=1, all strobes 0, state held until reset.
REQ-032 Zero-wait latency SHALL be:
- 4 cycles for ALU, JAL and JALR;
- 4 cycles for store;
- 5 cycles for load;
- 3 cycles for branch.

Reset
REQ-033 While rst_n=0, state SHALL be FETCH, counter 0, trap 0, and all strobes 0, irrespective of clk.
REQ-034 On release, imem_req SHALL assert in the first cycle.
REQ-035 Reset asserted mid-MEM SHALL drop dmem_req immediately (asynchronously).

Verification
REQ-036 ALU path: op=0110011, acks immediate -> states 0,1,2,4,0; rf_we and pc_we high in cycle 4 only, pc_sel=00.
REQ-037 Load: op=0000011, dmem_ack after 3 wait cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with rf_we=1.
REQ-038 Branch: op=1100011, funct3=000, br_taken=1 -> EXEC asserts pc_we=1 with pc_sel=01, returns to FETCH, rf_we never high.
REQ-039 Illegal: op=1111111 -> DECODE goes to TRAP; trap=1 persists 20 cycles with no strobes until rst_n=0.
REQ-040 Timeout: TIMEOUT=3, imem_ack held 0 -> TRAP entered after 4 FETCH cycles; repeat with ack on the 4th cycle -> DECODE, no trap.
REQ-041 Async reset: rst_n pulsed low between clock edges during MEM (store) -> dmem_req and dmem_we drop to 0 before the next edge; state=0 after release.
